// File: rtl/prg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prg_loader_pkg
// Description : Shared types and constants for the program-image loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prg_loader_pkg;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_ACK    = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // Legal values for the load-address header length.
    localparam int c_HDR_NONE = 0;
    localparam int c_HDR_LE16 = 2;

endpackage
`default_nettype wire

// File: rtl/prg_loader.sv
`default_nettype none
// ============================================================================
// Module      : prg_loader
// Description : Streams an hps_io ioctl download into a byte-wide target RAM
//               port, with optional little-endian load-address header,
//               optional write acknowledge, start/end reporting, overflow
//               detection and a completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module prg_loader
    import prg_loader_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          HDR_BYTES = 2,
    parameter logic [7:0]  INDEX     = 8'h41,
    parameter logic [15:0] DEF_ADDR  = 16'h0401,
    parameter bit          WAIT_ACK  = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] load_start,
    output logic [ADDR_W-1:0] load_end,
    output logic              done,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] c_DEF_ADDR = ADDR_W'(DEF_ADDR);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam bit                c_HAS_HDR  = (HDR_BYTES == c_HDR_LE16);

    state_t              r_state;
    logic                r_dl_q;      // previous ioctl_download, for edge detect
    logic [ADDR_W-1:0]   r_ptr;       // next target address
    logic [ADDR_W:0]     r_count;     // bytes actually written this load
    logic                r_fin_pend;  // download ended while a write was pending

    logic                w_dl_rise;
    logic                w_dl_fall;
    logic [15:0]         w_hdr16;
    logic [ADDR_W-1:0]   w_hdr_addr;

    assign w_dl_rise  = ioctl_download & ~r_dl_q;
    assign w_dl_fall  = ~ioctl_download & r_dl_q;
    // Header high byte joined with the latched low byte; bits above ADDR_W drop.
    assign w_hdr16    = {ioctl_dout, r_ptr[7:0]};
    assign w_hdr_addr = ADDR_W'(w_hdr16);

    // Loader FSM with pointer, counter and all registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_dl_q     <= 1'b0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_fin_pend <= 1'b0;
            ioctl_wait <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            load_start <= '0;
            load_end   <= '0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            r_dl_q <= ioctl_download;
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dl_rise && (ioctl_index == INDEX)) begin
                        ovf        <= 1'b0;
                        busy       <= 1'b1;
                        r_count    <= '0;
                        r_fin_pend <= 1'b0;
                        if (c_HAS_HDR) begin
                            r_state <= ST_HDR_LO;
                        end else begin
                            r_ptr      <= c_DEF_ADDR;
                            load_start <= c_DEF_ADDR;
                            r_state    <= ST_DATA;
                        end
                    end
                end
                ST_HDR_LO: begin
                    if (w_dl_fall) begin
                        // Truncated header: no valid load address exists.
                        load_start <= '0;
                        load_end   <= '0;
                        ovf        <= 1'b1;
                        done       <= 1'b1;
                        r_state    <= ST_FIN;
                    end else if (ioctl_wr) begin
                        r_ptr[7:0] <= ioctl_dout;
                        r_state    <= ST_HDR_HI;
                    end
                end
                ST_HDR_HI: begin
                    if (w_dl_fall) begin
                        load_start <= '0;
                        load_end   <= '0;
                        ovf        <= 1'b1;
                        done       <= 1'b1;
                        r_state    <= ST_FIN;
                    end else if (ioctl_wr) begin
                        r_ptr      <= w_hdr_addr;
                        load_start <= w_hdr_addr;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_dl_fall) begin
                        if (r_count == '0) begin
                            load_end <= load_start;
                        end
                        done    <= 1'b1;
                        r_state <= ST_FIN;
                    end else if (ioctl_wr && !ovf) begin
                        // Once the pointer has wrapped, bytes are silently swallowed.
                        mem_addr <= r_ptr;
                        mem_dout <= ioctl_dout;
                        mem_we   <= 1'b1;
                        load_end <= r_ptr;
                        r_ptr    <= r_ptr + c_ADDR_ONE;
                        r_count  <= r_count + c_CNT_ONE;
                        if (r_ptr == c_ADDR_MAX) begin
                            ovf <= 1'b1;
                        end
                        if (WAIT_ACK) begin
                            ioctl_wait <= 1'b1;
                            r_state    <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    // Strobes arriving here violate the wait protocol and are dropped.
                    if (w_dl_fall) begin
                        r_fin_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        ioctl_wait <= 1'b0;
                        if (r_fin_pend || w_dl_fall) begin
                            done    <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_FIN: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prg_loader
// Description : Self-checking bench for prg_loader. One instance uses the
//               2-byte header with acknowledged writes, a second uses the
//               headerless fire-and-forget configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prg_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        mem_ack = 1'b0;

    logic        a_wait, a_we, a_busy, a_done, a_ovf;
    logic [15:0] a_addr, a_start, a_end;
    logic [7:0]  a_dout;
    logic        b_wait, b_we, b_busy, b_done, b_ovf;
    logic [15:0] b_addr, b_start, b_end;
    logic [7:0]  b_dout;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [23:0] wq_a[$];
    logic [23:0] wq_b[$];
    int          done_a = 0;
    int          done_b = 0;
    bit          busy_seen_a = 1'b0;
    bit          wait_seen_b = 1'b0;
    int          ack_pend = 0;
    bit          ack_en = 1'b1;

    always #5 clk_sys = ~clk_sys;

    prg_loader #(
        .ADDR_W(16), .HDR_BYTES(2), .INDEX(8'h41), .DEF_ADDR(16'h0401), .WAIT_ACK(1'b1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(a_wait), .mem_addr(a_addr), .mem_dout(a_dout), .mem_we(a_we),
        .mem_ack(mem_ack), .busy(a_busy), .load_start(a_start), .load_end(a_end),
        .done(a_done), .ovf(a_ovf)
    );

    prg_loader #(
        .ADDR_W(16), .HDR_BYTES(0), .INDEX(8'h41), .DEF_ADDR(16'h0401), .WAIT_ACK(1'b0)
    ) dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(b_wait), .mem_addr(b_addr), .mem_dout(b_dout), .mem_we(b_we),
        .mem_ack(mem_ack), .busy(b_busy), .load_start(b_start), .load_end(b_end),
        .done(b_done), .ovf(b_ovf)
    );

    // Monitors plus a target RAM that acknowledges two cycles after each write.
    always @(negedge clk_sys) begin
        if (a_we) wq_a.push_back({a_addr, a_dout});
        if (b_we) wq_b.push_back({b_addr, b_dout});
        if (a_done) done_a++;
        if (b_done) done_b++;
        if (a_busy) busy_seen_a = 1'b1;
        if (b_wait) wait_seen_b = 1'b1;
        mem_ack = 1'b0;
        if (ack_pend == 1) mem_ack = 1'b1;
        if (ack_pend > 0) ack_pend--;
        if (a_we && ack_en) ack_pend = 2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    // Present one byte, then follow ioctl_wait until released (bounded).
    task automatic send_byte(input logic [7:0] b, output int wcyc, output logic we1);
        int guard;
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        tick();
        ioctl_wr = 1'b0;
        we1      = a_we;
        wcyc     = 0;
        guard    = 0;
        while (a_wait && guard < 40) begin
            wcyc++;
            guard++;
            tick();
        end
        if (guard >= 40) check("wait_bound", 32'(a_wait), 32'd0);
        tick();
    endtask

    task automatic begin_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_load();
        ioctl_download = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    // Full headered load on the acked instance, checked against arithmetic
    // expectations: byte i goes to start+i while that stays within 16 bits.
    task automatic do_load(input string tag, input logic [15:0] start, input logic [7:0] data[$]);
        logic [23:0] exp_q[$];
        int          w;
        int          d0;
        logic        we1;
        logic [16:0] a;
        bit          eovf;
        logic [15:0] eend;
        wq_a.delete();
        d0   = done_a;
        eovf = 1'b0;
        eend = start;
        begin_load(8'h41);
        send_byte(start[7:0], w, we1);
        check({tag, "_hdr_wait"}, 32'(w), 32'd0);
        send_byte(start[15:8], w, we1);
        check({tag, "_busy"}, 32'(a_busy), 32'd1);
        for (int i = 0; i < data.size(); i++) begin
            a = 17'(start) + 17'(i);
            if (a <= 17'h0FFFF) begin
                exp_q.push_back({a[15:0], data[i]});
                eend = a[15:0];
            end
            if (a >= 17'h0FFFF) eovf = 1'b1;
            send_byte(data[i], w, we1);
            check({tag, "_we_with_wait"}, 32'(we1), (a <= 17'h0FFFF) ? 32'd1 : 32'd0);
            check({tag, "_wait_cycles"}, 32'(w), (a <= 17'h0FFFF) ? 32'd3 : 32'd0);
        end
        end_load();
        check({tag, "_nwrites"}, 32'(wq_a.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wq_a.size()) check({tag, "_write"}, 32'(wq_a[i]), 32'(exp_q[i]));
        end
        check({tag, "_load_start"}, 32'(a_start), 32'(start));
        check({tag, "_load_end"}, 32'(a_end), 32'(eend));
        check({tag, "_ovf"}, 32'(a_ovf), 32'(eovf));
        check({tag, "_done"}, 32'(done_a), 32'(d0 + 1));
        check({tag, "_busy_after"}, 32'(a_busy), 32'd0);
    endtask

    initial begin
        logic [7:0]  dq[$];
        int          w;
        int          d0;
        int          db0;
        int          n;
        logic        we1;
        logic [15:0] st;

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 8'h00;
        tick();
        tick();
        check("rst_wait", 32'(a_wait), 32'd0);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_dout", 32'(a_dout), 32'd0);
        check("rst_start", 32'(a_start), 32'd0);
        check("rst_end", 32'(a_end), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();

        // Basic three-byte load.
        dq.delete();
        dq.push_back(8'hAA);
        dq.push_back(8'hBB);
        dq.push_back(8'hCC);
        do_load("basic", 16'h0401, dq);

        // Wrap at the top of the address space.
        dq.delete();
        dq.push_back(8'h11);
        dq.push_back(8'h22);
        dq.push_back(8'h33);
        dq.push_back(8'h44);
        do_load("wrap", 16'hFFFE, dq);

        // Header only, no data.
        dq.delete();
        do_load("empty", 16'h1000, dq);

        // Truncated header.
        wq_a.delete();
        d0 = done_a;
        begin_load(8'h41);
        send_byte(8'h34, w, we1);
        end_load();
        check("trunc_done", 32'(done_a), 32'(d0 + 1));
        check("trunc_ovf", 32'(a_ovf), 32'd1);
        check("trunc_start", 32'(a_start), 32'd0);
        check("trunc_end", 32'(a_end), 32'd0);
        check("trunc_nwrites", 32'(wq_a.size()), 32'd0);

        // Reset while a write is waiting for its acknowledge.
        ack_en = 1'b0;
        begin_load(8'h41);
        send_byte(8'h00, w, we1);
        send_byte(8'h20, w, we1);
        d0         = done_a;
        ioctl_wr   = 1'b1;
        ioctl_dout = 8'h77;
        tick();
        ioctl_wr = 1'b0;
        check("ack_entry_wait", 32'(a_wait), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_ack_wait", 32'(a_wait), 32'd0);
        check("rst_ack_we", 32'(a_we), 32'd0);
        check("rst_ack_busy", 32'(a_busy), 32'd0);
        ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        ack_en  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rst_ack_no_done", 32'(done_a), 32'(d0));
        check("rst_ack_busy_after", 32'(a_busy), 32'd0);
        dq.delete();
        for (int i = 0; i < 3; i++) dq.push_back(8'($urandom));
        do_load("after_rst", 16'h2000, dq);

        // Download to another index is ignored.
        busy_seen_a = 1'b0;
        wq_a.delete();
        wq_b.delete();
        d0  = done_a;
        db0 = done_b;
        begin_load(8'h01);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h60 + i), w, we1);
            check("other_idx_wait", 32'(w), 32'd0);
        end
        end_load();
        check("other_idx_busy", 32'(busy_seen_a), 32'd0);
        check("other_idx_writes_a", 32'(wq_a.size()), 32'd0);
        check("other_idx_writes_b", 32'(wq_b.size()), 32'd0);
        check("other_idx_done", 32'(done_a), 32'(d0));
        check("other_idx_done_b", 32'(done_b), 32'(db0));

        // Headerless fire-and-forget instance: first byte lands at 0401.
        wq_b.delete();
        db0 = done_b;
        begin_load(8'h41);
        send_byte(8'h55, w, we1);
        end_load();
        check("hdr0_nwrites", 32'(wq_b.size()), 32'd1);
        if (wq_b.size() > 0) check("hdr0_write", 32'(wq_b[0]), 32'h040155);
        check("hdr0_done", 32'(done_b), 32'(db0 + 1));
        check("hdr0_start", 32'(b_start), 32'h0401);
        check("hdr0_end", 32'(b_end), 32'h0401);
        check("hdr0_ovf", 32'(b_ovf), 32'd0);
        check("hdr0_wait_never", 32'(wait_seen_b), 32'd0);

        // Randomized loads, biased toward the top of the address space.
        for (int k = 0; k < 6; k++) begin
            dq.delete();
            n = $urandom_range(0, 6);
            for (int j = 0; j < n; j++) dq.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0) st = 16'hFFFF - 16'($urandom_range(0, 5));
            else st = 16'($urandom);
            do_load("rand", st, dq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
